// File: rtl/hilo_muldiv_unit.sv
// HI/LO unit: iterative shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator; signs are stripped on accept and restored at commit.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_raw_a;
  logic                 r_is_div, r_neg_lo, r_neg_hi, r_dz;
  logic                 r_done, r_dbz;
  logic [WIDTH-1:0]     r_hi, r_lo;

  logic signed [WIDTH-1:0] w_a_s, w_b_s;
  logic                    w_a_neg, w_b_neg, w_accept, w_start;
  logic [WIDTH-1:0]        w_a_mag, w_b_mag;
  logic [WIDTH:0]          w_mul_sum, w_div_top, w_div_diff;
  logic [2*WIDTH-1:0]      w_acc_mul, w_acc_div;

  always_comb begin
    w_a_s     = signed'(src_a);
    w_b_s     = signed'(src_b);
    // op[0]==0 selects the signed variants (MULT, DIV)
    w_a_neg   = ~op[0] & (w_a_s < 0);
    w_b_neg   = ~op[0] & (w_b_s < 0);
    w_a_mag   = neg_w(src_a, w_a_neg);
    w_b_mag   = neg_w(src_b, w_b_neg);
    w_accept  = (r_state == S_IDLE) && op_valid && (op <= 3'd5);
    w_start   = w_accept && (op <= 3'd3);

    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_acc_mul  = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_div_top - {1'b0, r_opnd};
    w_acc_div  = w_div_diff[WIDTH] ? {w_div_top[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = op[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:   if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_raw_a  <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (w_accept) r_dbz <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt    <= '0;
            r_raw_a  <= src_a;
            r_is_div <= op[1];
            r_dz     <= op[1] && (src_b == '0);
            r_neg_lo <= w_a_neg ^ w_b_neg;
            // remainder follows the dividend's sign
            r_neg_hi <= op[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_opnd   <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
          end else if (w_accept && op == 3'd4) begin
            r_hi <= src_a;
          end else if (w_accept && op == 3'd5) begin
            r_lo <= src_a;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_mul;
          r_cnt <= r_cnt + CW'(1);
        end
        S_DIV: begin
          r_acc <= w_acc_div;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_dbz <= r_dz;
          if (!r_is_div) begin
            {r_hi, r_lo} <= neg_2w(r_acc, r_neg_lo);
          end else if (r_dz) begin
            r_hi <= r_raw_a;
            r_lo <= '1;
          end else begin
            r_hi <= neg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_hi);
            r_lo <= neg_w(r_acc[WIDTH-1:0], r_neg_lo);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus randomized ops against a
// plain-arithmetic reference model.
module tb_hilo_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint q, r, p;
    logic [63:0] u;
    edz = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {eh, el} = p; end
      3'd1: begin u = {32'b0, a} * {32'b0, b}; {eh, el} = u; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          el = 32'hFFFF_FFFF; eh = a; edz = 1'b1;
        end else if (o == 3'd2) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output bit held);
    logic [31:0] h0, l0;
    h0 = hi_out; l0 = lo_out;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    lat = 0; bcnt = busy ? 1 : 0; held = 1'b1;
    while (!done && lat < 100) begin
      if (hi_out !== h0 || lo_out !== l0) held = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_dbz got=%b exp=0", div_by_zero); end
    total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL rst_hi got=%h exp=0", hi_out); end
    total++; if (lo_out !== 32'h0) begin bad++; $display("FAIL rst_lo got=%h exp=0", lo_out); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bcnt; bit held;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, lat, bcnt, held);
    total++; if (lat !== 33) begin bad++; $display("FAIL t1_latency got=%0d exp=33", lat); end
    total++; if (hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL t1_hi got=%h exp=ffffffff", hi_out); end
    total++; if (lo_out !== 32'hFFFF_FFEB) begin bad++; $display("FAIL t1_lo got=%h exp=ffffffeb", lo_out); end
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, held);
    total++; if (bcnt !== 33) begin bad++; $display("FAIL t2_busy_cycles got=%0d exp=33", bcnt); end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL t2_hilo_held got=%b exp=1", held); end
    total++; if (hi_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL t2_hi got=%h exp=fffffffe", hi_out); end
    total++; if (lo_out !== 32'h0000_0001) begin bad++; $display("FAIL t2_lo got=%h exp=00000001", lo_out); end
  endtask

  task automatic test_div();
    logic [2:0]  to [3] = '{3'd3, 3'd2, 3'd2};
    logic [31:0] ta [3] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] tb [3] = '{32'd7, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] tl [3] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] th [3] = '{32'd2, 32'hFFFF_FFFF, 32'h0};
    int lat, bcnt; bit held;
    for (int i = 0; i < 3; i++) begin
      run_op(to[i], ta[i], tb[i], lat, bcnt, held);
      total++; if (lo_out !== tl[i]) begin bad++; $display("FAIL t3_lo[%0d] got=%h exp=%h", i, lo_out, tl[i]); end
      total++; if (hi_out !== th[i]) begin bad++; $display("FAIL t3_hi[%0d] got=%h exp=%h", i, hi_out, th[i]); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL t3_dbz[%0d] got=%b exp=0", i, div_by_zero); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt, n; bit held;
    run_op(3'd2, 32'd5, 32'd0, lat, bcnt, held);
    total++; if (lat !== 33) begin bad++; $display("FAIL t4_latency got=%0d exp=33", lat); end
    total++; if (lo_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL t4_lo got=%h exp=ffffffff", lo_out); end
    total++; if (hi_out !== 32'd5) begin bad++; $display("FAIL t4_hi got=%h exp=5", hi_out); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL t4_dbz got=%b exp=1", div_by_zero); end
    op_valid = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    op_valid = 1'b0;
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL t4_dbz_clear got=%b exp=0", div_by_zero); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_b2b_busy got=%b exp=1", busy); end
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (lo_out !== 32'd12) begin bad++; $display("FAIL t4_b2b_lo got=%h exp=c", lo_out); end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    op_valid = 1'b1; op = 3'd4; src_a = 32'h1234;
    @(posedge clk); #1;
    total++; if (hi_out !== 32'h1234) begin bad++; $display("FAIL t5_mthi got=%h exp=1234", hi_out); end
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t5_mthi_flags got=%b%b exp=00", done, busy); end
    op = 3'd5; src_a = 32'h5678;
    @(posedge clk); #1;
    total++; if (lo_out !== 32'h5678) begin bad++; $display("FAIL t5_mtlo got=%h exp=5678", lo_out); end
    op = 3'd6; src_a = 32'hAAAA;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || lo_out !== 32'h5678 || hi_out !== 32'h1234) begin
      bad++; $display("FAIL t5_op6 got=%b/%h/%h exp=0/00005678/00001234", busy, lo_out, hi_out); end
    op = 3'd0; src_a = 32'h100; src_b = 32'h100;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op_valid = 1'b1; op = 3'd5; src_a = 32'hDEAD;
    @(posedge clk); #1;
    op_valid = 1'b0;
    total++; if (lo_out !== 32'h5678) begin bad++; $display("FAIL t5_mtlo_busy got=%h exp=5678", lo_out); end
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (lo_out !== 32'h10000 || hi_out !== 32'h0) begin
      bad++; $display("FAIL t5_mult_commit got=%h_%h exp=00000000_00010000", hi_out, lo_out); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt; bit held;
    op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL t6_flags got=%b%b exp=00", busy, done); end
    total++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin bad++; $display("FAIL t6_hilo got=%h_%h exp=0_0", hi_out, lo_out); end
    run_op(3'd0, 32'd2, 32'd3, lat, bcnt, held);
    total++; if (lat !== 33) begin bad++; $display("FAIL t6_latency got=%0d exp=33", lat); end
    total++; if (lo_out !== 32'd6 || hi_out !== 32'd0) begin bad++; $display("FAIL t6_mult got=%h_%h exp=0_6", hi_out, lo_out); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    logic        edz;
    int lat, bcnt; bit held;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      model(o, a, b, eh, el, edz);
      run_op(o, a, b, lat, bcnt, held);
      total++; if (lat !== 33) begin bad++; $display("FAIL rand_lat op=%0d got=%0d exp=33", o, lat); end
      total++; if (hi_out !== eh) begin bad++; $display("FAIL rand_hi op=%0d a=%h b=%h got=%h exp=%h", o, a, b, hi_out, eh); end
      total++; if (lo_out !== el) begin bad++; $display("FAIL rand_lo op=%0d a=%h b=%h got=%h exp=%h", o, a, b, lo_out, el); end
      total++; if (div_by_zero !== edz) begin bad++; $display("FAIL rand_dbz op=%0d b=%h got=%b exp=%b", o, b, div_by_zero, edz); end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL rand_partial op=%0d got=%b exp=1", o, held); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
